// File: rtl/game_referee_if.sv
// game_referee_if
//   Bundles the referee's inputs (round control, frame strobe, sprite
//   positions) and its result outputs.
//   master : the game-logic side that drives start/vblnk/positions and
//            consumes gameover/playing/time_left.
//   slave  : the referee itself.
//   Signals:
//     start             level, begin/restart a round
//     vblnk             vertical blank, rising edge = frame tick
//     tom_x, tom_y      Tom top-left corner, unsigned pixels
//     jerry_x, jerry_y  Jerry top-left corner, unsigned pixels
//     gameover          00 running/idle, 01 caught, 10 time expired
//     playing           high while a round is in progress
//     time_left         remaining whole seconds
interface game_referee_if;
    logic        start;
    logic        vblnk;
    logic [11:0] tom_x;
    logic [11:0] tom_y;
    logic [11:0] jerry_x;
    logic [11:0] jerry_y;
    logic [1:0]  gameover;
    logic        playing;
    logic [7:0]  time_left;

    modport master (
        output start, vblnk, tom_x, tom_y, jerry_x, jerry_y,
        input  gameover, playing, time_left
    );

    modport slave (
        input  start, vblnk, tom_x, tom_y, jerry_x, jerry_y,
        output gameover, playing, time_left
    );
endinterface

// File: rtl/game_referee.sv
// game_referee
//   Round referee for the Tom & Jerry game. Once per video frame (rising
//   edge of vblnk) it checks whether the two sprite bounding boxes overlap
//   and advances the round countdown. A catch is confirmed after
//   CATCH_FRAMES consecutive overlapping frames; the round times out when
//   the countdown reaches zero. The result is held until start or rst.
//   Ports:
//     clk  pixel clock
//     rst  synchronous active-high reset
//     bus  game_referee_if.slave (start, vblnk, positions in;
//          gameover, playing, time_left out, all registered)
module game_referee #(
    parameter int FPS           = 60,
    parameter int ROUND_SECONDS = 90,
    parameter int TOM_W         = 64,
    parameter int TOM_H         = 64,
    parameter int JERRY_W       = 32,
    parameter int JERRY_H       = 32,
    parameter int CATCH_FRAMES  = 3
) (
    input  logic          clk,
    input  logic          rst,
    game_referee_if.slave bus
);

    localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;

    localparam logic [FW-1:0] FRAME_LAST  = FW'(FPS - 1);
    localparam logic [7:0]    TIME_INIT   = 8'(ROUND_SECONDS);
    localparam logic [3:0]    CATCH_MAX   = 4'(CATCH_FRAMES);
    localparam logic [3:0]    CATCH_LAST  = 4'(CATCH_FRAMES - 1);

    localparam logic [1:0] GO_NONE  = 2'b00;
    localparam logic [1:0] GO_CATCH = 2'b01;
    localparam logic [1:0] GO_TIME  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gameover_q, gameover_d;
    logic          playing_q, playing_d;
    logic [7:0]    time_left_q, time_left_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]    catch_cnt_q, catch_cnt_d;
    logic          vblnk_prev_q;

    logic tick;
    logic overlap;
    logic wrap;
    logic catch_hit;
    logic time_hit;

    assign tick = bus.vblnk & ~vblnk_prev_q;

    // One extra bit on every sum so a sprite near x/y = 4095 cannot wrap
    // around and fake an overlap. Strict compares: shared edges don't count.
    always_comb begin
        overlap = ({1'b0, bus.tom_x}   < ({1'b0, bus.jerry_x} + 13'(JERRY_W))) &&
                  ({1'b0, bus.jerry_x} < ({1'b0, bus.tom_x}   + 13'(TOM_W)))   &&
                  ({1'b0, bus.tom_y}   < ({1'b0, bus.jerry_y} + 13'(JERRY_H))) &&
                  ({1'b0, bus.jerry_y} < ({1'b0, bus.tom_y}   + 13'(TOM_H)));
    end

    assign wrap      = (frame_cnt_q == FRAME_LAST);
    assign catch_hit = overlap && (catch_cnt_q == CATCH_LAST);
    assign time_hit  = wrap && (time_left_q == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gameover_q   <= GO_NONE;
            playing_q    <= 1'b0;
            time_left_q  <= TIME_INIT;
            frame_cnt_q  <= '0;
            catch_cnt_q  <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gameover_q   <= gameover_d;
            playing_q    <= playing_d;
            time_left_q  <= time_left_d;
            frame_cnt_q  <= frame_cnt_d;
            catch_cnt_q  <= catch_cnt_d;
            vblnk_prev_q <= bus.vblnk;
        end
    end

    always_comb begin
        state_d     = state_q;
        gameover_d  = gameover_q;
        playing_d   = playing_q;
        time_left_d = time_left_q;
        frame_cnt_d = frame_cnt_q;
        catch_cnt_d = catch_cnt_q;

        unique case (state_q)
            IDLE, OVER: begin
                // Restart from OVER is identical to a fresh start from IDLE.
                if (bus.start) begin
                    state_d     = PLAY;
                    gameover_d  = GO_NONE;
                    playing_d   = 1'b1;
                    time_left_d = TIME_INIT;
                    frame_cnt_d = '0;
                    catch_cnt_d = '0;
                end
            end

            PLAY: begin
                if (tick) begin
                    if (!overlap) begin
                        catch_cnt_d = '0;
                    end else if (catch_cnt_q != CATCH_MAX) begin
                        catch_cnt_d = catch_cnt_q + 4'd1;
                    end

                    if (wrap) begin
                        frame_cnt_d = '0;
                        time_left_d = time_left_q - 8'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end

                    // A catch on the expiry tick still wins; time_left has
                    // already been decremented to 0 above in that case.
                    if (catch_hit) begin
                        state_d    = OVER;
                        gameover_d = GO_CATCH;
                        playing_d  = 1'b0;
                    end else if (time_hit) begin
                        state_d     = OVER;
                        gameover_d  = GO_TIME;
                        playing_d   = 1'b0;
                        time_left_d = 8'd0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gameover  = gameover_q;
    assign bus.playing   = playing_q;
    assign bus.time_left = time_left_q;

endmodule
